// File: rtl/ft245_bridge.sv
// FT245-style parallel-FIFO bridge: TX/RX byte FIFOs, pad flag synchronizers and a
// strobe-timing FSM with fair read/write arbitration. Optional macro: FT245_LOOPBACK_EN.

module ft245_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign full    = (level == LVL_MAX);
    assign empty   = (level == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push_en && !pop_en)      level <= level + LVL_ONE;
            else if (pop_en && !push_en) level <= level - LVL_ONE;
        end
    end

    // Storage is not reset; a flush only needs the pointers and level cleared.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end
endmodule

// state     | meaning
// IDLE      | waiting; arbitrates between pending write and read
// WR_SETUP  | bus driven with TX head, pad_wr_n still high
// WR_STROBE | pad_wr_n low for WR_CYC cycles
// WR_HOLD   | pad_wr_n high, data held; TX head popped
// RD_STROBE | pad_rd_n low for RD_CYC cycles; sample on last cycle
// GAP       | GAP_CYC+2 guard cycles; the last one is also an arbitration slot
module ft245_bridge #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int WR_CYC   = 2,
    parameter int RD_CYC   = 3,
    parameter int GAP_CYC  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef FT245_LOOPBACK_EN
    input  logic                        loopback,
`endif
    input  logic [DATA_W-1:0]           pad_data_i,
    output logic [DATA_W-1:0]           pad_data_o,
    output logic                        pad_data_oe,
    input  logic                        pad_txe_n,
    input  logic                        pad_rxf_n,
    output logic                        pad_wr_n,
    output logic                        pad_rd_n,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_W-1:0]           tx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [DATA_W-1:0]           rx_data,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);
    localparam int MAXC_WR = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int MAXC    = (MAXC_WR > GAP_CYC + 2) ? MAXC_WR : GAP_CYC + 2;
    localparam int CNT_W   = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, GAP
    } state_t;

    typedef enum logic {DIR_WRITE, DIR_READ} dir_t;

    state_t            state, nxt;
    dir_t              last_dir, dir_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              txe_meta, txe_s;
    logic              rxf_meta, rxf_s;
    logic              lb_mode;
    logic              wr_ok, rd_ok;
    logic              arb;
    logic              tx_pop, rx_push_pad, lb_xfer;
    logic              wr_phase_nxt;

    logic [DATA_W-1:0] tx_head;
    logic              tx_full, tx_empty;
    logic              rx_full, rx_empty;

`ifdef FT245_LOOPBACK_EN
    assign lb_mode = loopback;
`else
    assign lb_mode = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            txe_meta <= pad_txe_n;
            txe_s    <= txe_meta;
            rxf_meta <= pad_rxf_n;
            rxf_s    <= rxf_meta;
        end
    end

    ft245_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop | lb_xfer),
        .head      (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    ft245_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push_pad | lb_xfer),
        .push_data (lb_xfer ? tx_head : pad_data_i),
        .pop       (rx_ready),
        .head      (rx_data),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    assign wr_ok = !txe_s && !tx_empty && !lb_mode;
    assign rd_ok = !rxf_s && !rx_full && !lb_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last_dir <= DIR_WRITE;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            last_dir <= dir_nxt;
        end
    end

    always_comb begin
        nxt         = state;
        cnt_nxt     = cnt;
        dir_nxt     = last_dir;
        tx_pop      = 1'b0;
        rx_push_pad = 1'b0;
        lb_xfer     = 1'b0;
        arb         = 1'b0;
        case (state)
            IDLE: arb = 1'b1;
            WR_SETUP: begin
                nxt     = WR_STROBE;
                cnt_nxt = WR_LOAD;
            end
            WR_STROBE: begin
                if (cnt == '0) nxt = WR_HOLD;
                else           cnt_nxt = cnt - CNT_ONE;
            end
            WR_HOLD: begin
                tx_pop  = 1'b1;
                dir_nxt = DIR_WRITE;
                nxt     = GAP;
                cnt_nxt = GAP_LOAD;
            end
            RD_STROBE: begin
                if (cnt == '0) begin
                    rx_push_pad = 1'b1;
                    dir_nxt     = DIR_READ;
                    nxt         = GAP;
                    cnt_nxt     = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    nxt = IDLE;
                    arb = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: nxt = IDLE;
        endcase

        // When both sides are ready, the direction not taken last time wins.
        if (arb) begin
            if (lb_mode) begin
                lb_xfer = !tx_empty && !rx_full;
            end else if (wr_ok && (!rd_ok || last_dir == DIR_READ)) begin
                nxt = WR_SETUP;
            end else if (rd_ok) begin
                nxt     = RD_STROBE;
                cnt_nxt = RD_LOAD;
            end
        end
    end

    assign wr_phase_nxt = (nxt == WR_SETUP) || (nxt == WR_STROBE) || (nxt == WR_HOLD);

    // Pad outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_wr_n    <= 1'b1;
            pad_rd_n    <= 1'b1;
            pad_data_oe <= 1'b0;
            pad_data_o  <= '0;
        end else begin
            pad_wr_n    <= (nxt != WR_STROBE);
            pad_rd_n    <= (nxt != RD_STROBE);
            pad_data_oe <= wr_phase_nxt;
            pad_data_o  <= wr_phase_nxt ? tx_head : '0;
        end
    end
endmodule

// File: tb/tb_ft245_bridge.sv
// Self-checking bench for ft245_bridge: vector table for the TX FIFO plus directed
// pad-timing sequences (write, read, RX full, alternation, async reset, loopback).

module tb_ft245_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pad_data_i;
    logic [7:0] pad_data_o;
    logic       pad_data_oe;
    logic       pad_txe_n, pad_rxf_n;
    logic       pad_wr_n, pad_rd_n;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic [2:0] tx_level, rx_level;
    logic       loopback;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_src [8];
    int         rd_total = 0;
    int         wr_total = 0;
    int         ev_total = 0;
    int         bus_err  = 0;
    logic [7:0] wr_log     [64];
    int         wr_w_log   [64];
    int         rd_w_log   [64];
    int         rd_gap_log [64];
    logic       ev_log     [64];
    logic       prev_wr = 1'b1, prev_rd = 1'b1;
    int         wr_lo = 0, rd_lo = 0, rd_hi = 0;

    assign pad_data_i = rd_src[rd_total % 8];

    always #5 clk = ~clk;

    ft245_bridge #(
        .DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .WR_CYC(2), .RD_CYC(3), .GAP_CYC(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FT245_LOOPBACK_EN
        .loopback    (loopback),
`endif
        .pad_data_i  (pad_data_i),
        .pad_data_o  (pad_data_o),
        .pad_data_oe (pad_data_oe),
        .pad_txe_n   (pad_txe_n),
        .pad_rxf_n   (pad_rxf_n),
        .pad_wr_n    (pad_wr_n),
        .pad_rd_n    (pad_rd_n),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_level    (tx_level),
        .rx_level    (rx_level)
    );

    // Pad-side observer: logs strobe widths, written bytes, read gaps and order (1 = write).
    always @(negedge clk) begin
        if (reset) begin
            prev_wr = 1'b1; prev_rd = 1'b1; wr_lo = 0; rd_lo = 0; rd_hi = 0;
        end else begin
            if (!pad_rd_n && pad_data_oe) bus_err++;
            if (!pad_wr_n) begin
                wr_lo++;
            end else if (!prev_wr) begin
                wr_log[wr_total % 64]   = pad_data_o;
                wr_w_log[wr_total % 64] = wr_lo;
                ev_log[ev_total % 64]   = 1'b1;
                wr_total++; ev_total++; wr_lo = 0;
            end
            if (!pad_rd_n) begin
                if (prev_rd) rd_gap_log[rd_total % 64] = rd_hi;
                rd_lo++;
            end else if (!prev_rd) begin
                rd_w_log[rd_total % 64] = rd_lo;
                ev_log[ev_total % 64]   = 1'b0;
                rd_total++; ev_total++; rd_lo = 0; rd_hi = 1;
            end else begin
                rd_hi++;
            end
            prev_wr = pad_wr_n;
            prev_rd = pad_rd_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_total < target && n < budget) begin step(1); n++; end
        chk("wr_timeout", 32'(wr_total >= target), 1);
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_total < target && n < budget) begin step(1); n++; end
        chk("rd_timeout", 32'(rd_total >= target), 1);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic [2:0] exp_level;
    } tx_vec_t;

    tx_vec_t vecs [7];

    initial begin
        int base, ebase, n;
        logic [7:0] exp_b [4];

        vecs[0] = '{1'b1, 8'h11, 1'b1, 3'd1};
        vecs[1] = '{1'b0, 8'hEE, 1'b1, 3'd1};
        vecs[2] = '{1'b1, 8'h22, 1'b1, 3'd2};
        vecs[3] = '{1'b1, 8'h33, 1'b1, 3'd3};
        vecs[4] = '{1'b1, 8'h44, 1'b1, 3'd4};
        vecs[5] = '{1'b1, 8'h55, 1'b0, 3'd4};
        vecs[6] = '{1'b0, 8'h66, 1'b0, 3'd4};

        for (int i = 0; i < 8; i++) rd_src[i] = 8'h00;
        reset = 1'b1; loopback = 1'b0;
        pad_txe_n = 1'b1; pad_rxf_n = 1'b1;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        step(3);
        chk("rst_wr_n", pad_wr_n, 1);
        chk("rst_rd_n", pad_rd_n, 1);
        chk("rst_oe", pad_data_oe, 0);
        chk("rst_data_o", pad_data_o, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        reset = 1'b0;
        step(1);
        chk("rst_tx_ready", tx_ready, 1);

        // TX fill to full with device not ready; overflow byte must be dropped.
        for (int i = 0; i < 7; i++) begin
            tx_valid = vecs[i].valid;
            tx_data  = vecs[i].data;
            chk($sformatf("vec%0d_ready", i), tx_ready, vecs[i].exp_ready);
            step(1);
            chk($sformatf("vec%0d_level", i), tx_level, vecs[i].exp_level);
        end
        tx_valid = 1'b0;
        chk("no_wr_when_txe_high", 32'(wr_total), 0);
        base = wr_total;
        pad_txe_n = 1'b0;
        wait_wr(base + 4, 200);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_byte%0d", i), wr_log[(base + i) % 64], exp_b[i]);
            chk($sformatf("drain_width%0d", i), wr_w_log[(base + i) % 64], 2);
        end
        step(20);
        chk("overflow_dropped", 32'(wr_total), 32'(base + 4));
        chk("drain_level", tx_level, 0);

        // Single write latency and bus hold.
        tx_valid = 1'b1; tx_data = 8'hA5;
        step(1);
        tx_valid = 1'b0;
        chk("a5_k_level", tx_level, 1);
        chk("a5_k_oe", pad_data_oe, 0);
        step(1);
        chk("a5_setup_wr_n", pad_wr_n, 1);
        chk("a5_setup_oe", pad_data_oe, 1);
        chk("a5_setup_data", pad_data_o, 8'hA5);
        step(1);
        chk("a5_strobe1_wr_n", pad_wr_n, 0);
        chk("a5_strobe1_data", pad_data_o, 8'hA5);
        step(1);
        chk("a5_strobe2_wr_n", pad_wr_n, 0);
        step(1);
        chk("a5_hold_wr_n", pad_wr_n, 1);
        chk("a5_hold_oe", pad_data_oe, 1);
        chk("a5_hold_data", pad_data_o, 8'hA5);
        step(1);
        chk("a5_gap_oe", pad_data_oe, 0);
        chk("a5_level", tx_level, 0);
        step(10);

        // Reads: width, sampled data, gap, RX-full stall and one-pop refill.
        base = rd_total;
        exp_b = '{8'h5A, 8'h69, 8'h96, 8'hC3};
        rd_src[base % 8] = 8'h3C;
        for (int i = 0; i < 4; i++) rd_src[(base + 1 + i) % 8] = exp_b[i];
        pad_rxf_n = 1'b0;
        wait_rd(base + 1, 50);
        chk("rd_width", rd_w_log[base % 64], 3);
        chk("rd_rx_valid", rx_valid, 1);
        chk("rd_rx_data", rx_data, 8'h3C);
        wait_rd(base + 4, 100);
        chk("rd_gap", rd_gap_log[(base + 1) % 64], 3);
        step(40);
        chk("rxfull_reads", 32'(rd_total), 32'(base + 4));
        chk("rxfull_level", rx_level, 4);
        chk("rxfull_rd_n", pad_rd_n, 1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        chk("pop_head", rx_data, 8'h5A);
        chk("pop_level", rx_level, 3);
        wait_rd(base + 5, 50);
        pad_rxf_n = 1'b1;
        step(40);
        chk("refill_reads", 32'(rd_total), 32'(base + 5));
        chk("refill_level", rx_level, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rx_order%0d", i), rx_data, exp_b[i]);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
        end
        chk("rx_empty", rx_valid, 0);

        // Alternation with both sides ready; first pick after reset is a read.
        pad_txe_n = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1; tx_data = 8'h81 + 8'(i);
            step(1);
        end
        tx_valid = 1'b0;
        base  = rd_total;
        ebase = ev_total;
        for (int i = 0; i < 4; i++) rd_src[(base + i) % 8] = 8'h91 + 8'(i);
        n = wr_total;
        pad_txe_n = 1'b0; pad_rxf_n = 1'b0;
        begin
            int t = 0;
            while (ev_total < ebase + 8 && t < 300) begin step(1); t++; end
            chk("alt_timeout", 32'(ev_total >= ebase + 8), 1);
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("alt_order%0d", i), ev_log[(ebase + i) % 64], 32'(i % 2));
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_wbyte%0d", i), wr_log[(n + i) % 64], 8'h81 + 8'(i));
        chk("alt_rx_level", rx_level, 4);
        chk("alt_rx_head", rx_data, 8'h91);
        chk("turnaround", 32'(bus_err), 0);

        // Asynchronous reset in the middle of a write strobe.
        pad_rxf_n = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h77;
        step(1);
        tx_valid = 1'b0;
        begin
            int t = 0;
            while (pad_wr_n && t < 30) begin step(1); t++; end
            chk("strobe_seen", pad_wr_n, 0);
        end
        #2 reset = 1'b1;
        #1;
        chk("async_wr_n", pad_wr_n, 1);
        chk("async_oe", pad_data_oe, 0);
        chk("async_tx_level", tx_level, 0);
        chk("async_rx_level", rx_level, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        pad_txe_n = 1'b1;
        step(2);
        chk("post_rst_tx_ready", tx_ready, 1);

`ifdef FT245_LOOPBACK_EN
        loopback = 1'b1;
        step(2);
        pad_txe_n = 1'b0; pad_rxf_n = 1'b0;
        base = wr_total; n = rd_total;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'h11 * 8'(i + 1);
            step(1);
        end
        tx_valid = 1'b0;
        step(20);
        chk("lb_rx_level", rx_level, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_byte%0d", i), rx_data, 8'h11 * 8'(i + 1));
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
        end
        chk("lb_no_wr", 32'(wr_total), 32'(base));
        chk("lb_no_rd", 32'(rd_total), 32'(n));
        loopback = 1'b0;
        pad_txe_n = 1'b1; pad_rxf_n = 1'b1;
        step(5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ft245_bridge.md
Name: ft245_bridge

Overview:
- Parametrised FT245-style parallel-FIFO bridge between a SubleqSOC-class core and an external USB FIFO chip.
- Replaces direct pad strobing from the core with:
  - buffered TX and RX FIFOs;
  - internal flag synchronizers;
  - a timing state machine that generates RD#/WR# pulses of configurable width and fairly arbitrates read and write traffic.
- Sits between the top-level pads and the core's valid/ready byte streams.

Parameters:
- DATA_W, 8, pad/stream data width.
- TX_DEPTH, 16, TX FIFO entries (power of two, >=2).
- RX_DEPTH, 16, RX FIFO entries (power of two, >=2).
- WR_CYC, 2, cycles pad_wr_n is held low per write (>=1).
- RD_CYC, 3, cycles pad_rd_n is held low per read; data is sampled on the last of these cycles (>=1).
- GAP_CYC, 1, extra idle cycles after each transfer, on top of the fixed 2-cycle flag-resync guard.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- pad_data_i  in  DATA_W  data bus input from the pad buffer.
- pad_data_o  out  DATA_W  data bus output to the pad buffer.
- pad_data_oe  out  1  1 = bridge drives the bus.
- pad_txe_n  in  1  device can accept a byte when low (asynchronous).
- pad_rxf_n  in  1  device has a byte when low (asynchronous).
- pad_wr_n  out  1  write strobe, active-low; device latches on the rising edge.
- pad_rd_n  out  1  read strobe, active-low.
- tx_valid  in  1  core offers a byte.
- tx_ready  out  1  TX FIFO not full.
- tx_data  in  DATA_W  byte to send.
- rx_valid  out  1  RX FIFO not empty (show-ahead).
- rx_ready  in  1  core consumes rx_data.
- rx_data  out  DATA_W  head of the RX FIFO.
- tx_level  out  clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  clog2(RX_DEPTH)+1  RX FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - pad_wr_n=1, pad_rd_n=1, pad_data_oe=0, pad_data_o=0.
  - Both FIFOs flushed: tx_level=0, rx_level=0, tx_ready=1 after release, rx_valid=0.
  - Synchronizer flops reset to 1 (device not ready).
  - FSM returns to IDLE; any in-flight transfer is abandoned; last_dir=WRITE.
- Flag synchronizers: 2 flops each; txe_s and rxf_s are the synchronized outputs.
- FIFO handshakes:
  - Push when tx_valid&&tx_ready; pop when rx_valid&&rx_ready.
  - tx_ready and rx_valid come from registered full/empty state.
  - A tx_valid while full is ignored, not stored.
  - rx_data is valid whenever rx_valid=1.
  - Pointers wrap modulo DEPTH; levels reach exactly DEPTH when full.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_STROBE, GAP.
- IDLE:
  - wr_ok = !txe_s && tx_level!=0.
  - rd_ok = !rxf_s && rx_level!=RX_DEPTH.
  - Only one true: take that direction.
  - Both true: take the opposite of last_dir (alternation, no starvation).
  - Neither true: stay in IDLE.
- WR_SETUP (1 cycle): pad_data_oe=1, pad_data_o=TX head, pad_wr_n=1.
- WR_STROBE (WR_CYC cycles): pad_wr_n=0; oe and data unchanged.
- WR_HOLD (1 cycle):
  - pad_wr_n=1, oe and data still held.
  - TX FIFO pops at the end of this state; last_dir=WRITE.
  - Then GAP.
- RD_STROBE (RD_CYC cycles):
  - pad_rd_n=0, pad_data_oe=0.
  - On the final cycle, pad_data_i is pushed into the RX FIFO; last_dir=READ.
  - pad_rd_n=1 in the following cycle; then GAP.
- GAP (GAP_CYC+2 cycles):
  - All strobes high, oe=0; flags are ignored so stale synchronized values cannot trigger a spurious transfer.
  - Then IDLE.
- Bus turnaround: oe is never 1 while pad_rd_n=0; there is at least 1 cycle with oe=0 between any write and a following read.
- Write latency: with txe_s already low, a byte accepted at edge k gives pad_wr_n falling at edge k+2.
- Throughput per write: WR_CYC+GAP_CYC+4 cycles. Per read: RD_CYC+GAP_CYC+2 cycles.
- RX full: no read starts; the device keeps its byte and pad_rxf_n stays low.
- Flag deasserted during a strobe: the strobe completes normally; the flag is only checked in IDLE.
- Same-cycle core push and FSM pop (or core pop and FSM push): both are performed and the level is unchanged.

Optional Feature:
- Macro FT245_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, a TX pop pushes the same byte directly into the RX FIFO.
  - The FSM never leaves IDLE/GAP for pad traffic; pads stay idle (strobes high, oe=0).
  - If the RX FIFO is full, the TX pop is stalled.
  - loopback=0 behaves exactly as the non-macro build.
- Undefined: port absent; pad-only behaviour as above.

Test Plan:
- Reset release, pad_txe_n=0, core sends 0xA5 -> pad_wr_n low for exactly 2 cycles starting 2 cycles after accept; pad_data_o=0xA5 with oe=1 from WR_SETUP through WR_HOLD; tx_level returns to 0.
- pad_rxf_n=0, pad_data_i=0x3C -> pad_rd_n low exactly 3 cycles; rx_valid=1 and rx_data=0x3C after sampling; a second read is not started until GAP has elapsed.
- Both sides ready continuously, TX loaded with 4 bytes, device supplies 4 bytes -> strobe order READ, WRITE, READ, WRITE...; oe=0 whenever pad_rd_n=0.
- RX_DEPTH=4, device always has data, rx_ready=0 -> exactly 4 reads, rx_level=4, pad_rd_n stays high; one pop -> exactly one more read.
- Assert reset during WR_STROBE -> pad_wr_n=1 and oe=0 in the same cycle (asynchronous); both levels=0.
- FT245_LOOPBACK_EN with loopback=1, send 0x11, 0x22, 0x33 -> received in order on rx_data; no pad strobe activity.
